// File: rtl/forward_unit.sv
// Operand-forwarding and load-use hazard unit between ID operand fetch and the EX ALU.
// Resolves each source operand against EX, MA and a short history of retired write-backs.
module forward_unit #(
    parameter int XLEN  = 32,
    parameter int NREAD = 2,
    parameter int HIST  = 1,
    parameter int RADDR = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREAD*RADDR-1:0] rs_id,
    input  logic [NREAD-1:0]       rs_used_id,
    input  logic [NREAD*XLEN-1:0]  op_id,
    input  logic [RADDR-1:0]       rd_ex,
    input  logic                   reg_we_ex,
    input  logic                   ex_is_load,
    input  logic [XLEN-1:0]        alu_result,
    input  logic [RADDR-1:0]       rd_ma,
    input  logic                   reg_we_ma,
    input  logic [XLEN-1:0]        reg_wdata,
    output logic [NREAD*XLEN-1:0]  op_out,
    output logic [NREAD*2-1:0]     fwd_sel,
    output logic                   load_use_stall,
    output logic [31:0]            stall_count
);

    localparam logic [1:0] SEL_RF   = 2'd0;
    localparam logic [1:0] SEL_EX   = 2'd1;
    localparam logic [1:0] SEL_MA   = 2'd2;
    localparam logic [1:0] SEL_HIST = 2'd3;

    logic             hist_we_q   [HIST];
    logic [RADDR-1:0] hist_rd_q   [HIST];
    logic [XLEN-1:0]  hist_data_q [HIST];

    logic [31:0]      stall_cnt_q;
    logic [31:0]      stall_cnt_d;

    logic [RADDR-1:0] rs_s;
    logic             ex_hit_s;
    logic             ma_hit_s;
    logic             hist_hit_s;
    logic [XLEN-1:0]  hist_data_s;
    logic             hist_match_s;

    // Per-port source selection with EX > MA > history (newest first) > register file.
    always_comb begin
        op_out         = '0;
        fwd_sel        = '0;
        load_use_stall = 1'b0;
        rs_s           = '0;
        ex_hit_s       = 1'b0;
        ma_hit_s       = 1'b0;
        hist_hit_s     = 1'b0;
        hist_data_s    = '0;
        hist_match_s   = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            rs_s     = rs_id[i*RADDR +: RADDR];
            ex_hit_s = reg_we_ex && (rd_ex != '0) && (rd_ex == rs_s);
            ma_hit_s = reg_we_ma && (rd_ma != '0) && (rd_ma == rs_s);

            // Walk oldest to newest so the newest matching entry overrides.
            hist_hit_s  = 1'b0;
            hist_data_s = '0;
            for (int h = HIST - 1; h >= 0; h--) begin
                hist_match_s = hist_we_q[h] && (hist_rd_q[h] != '0) && (hist_rd_q[h] == rs_s);
                hist_data_s  = hist_match_s ? hist_data_q[h] : hist_data_s;
                hist_hit_s   = hist_hit_s | hist_match_s;
            end

            if (rs_s == '0) begin
                op_out[i*XLEN +: XLEN] = op_id[i*XLEN +: XLEN];
                fwd_sel[i*2 +: 2]      = SEL_RF;
            end else if (ex_hit_s) begin
                op_out[i*XLEN +: XLEN] = alu_result;
                fwd_sel[i*2 +: 2]      = SEL_EX;
            end else if (ma_hit_s) begin
                op_out[i*XLEN +: XLEN] = reg_wdata;
                fwd_sel[i*2 +: 2]      = SEL_MA;
            end else if (hist_hit_s) begin
                op_out[i*XLEN +: XLEN] = hist_data_s;
                fwd_sel[i*2 +: 2]      = SEL_HIST;
            end else begin
                op_out[i*XLEN +: XLEN] = op_id[i*XLEN +: XLEN];
                fwd_sel[i*2 +: 2]      = SEL_RF;
            end

            // A load in EX has no value yet, so a real reader of its rd must wait a cycle.
            load_use_stall = load_use_stall | (rs_used_id[i] & ex_is_load & ex_hit_s);
        end
    end

    // Saturating next value of the stall-cycle counter.
    always_comb begin
        if (load_use_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // History shifts every edge, stall or not, because MA keeps retiring.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int h = 0; h < HIST; h++) begin
                hist_we_q[h]   <= 1'b0;
                hist_rd_q[h]   <= '0;
                hist_data_q[h] <= '0;
            end
            stall_cnt_q <= 32'd0;
        end else begin
            hist_we_q[0]   <= reg_we_ma;
            hist_rd_q[0]   <= rd_ma;
            hist_data_q[0] <= reg_wdata;
            for (int h = 1; h < HIST; h++) begin
                hist_we_q[h]   <= hist_we_q[h-1];
                hist_rd_q[h]   <= hist_rd_q[h-1];
                hist_data_q[h] <= hist_data_q[h-1];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_forward_unit.sv
// Scoreboard bench for forward_unit: a HIST=1 instance and a HIST=2 instance share all inputs.
module tb_forward_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  rs_id;
    logic [1:0]  rs_used_id;
    logic [63:0] op_id;
    logic [4:0]  rd_ex;
    logic        reg_we_ex;
    logic        ex_is_load;
    logic [31:0] alu_result;
    logic [4:0]  rd_ma;
    logic        reg_we_ma;
    logic [31:0] reg_wdata;

    logic [63:0] op_out,  op_out2;
    logic [3:0]  fwd_sel, fwd_sel2;
    logic        lus,     lus2;
    logic [31:0] cnt,     cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        bit          inst2;
        logic [63:0] op;
        logic [3:0]  sel;
        logic        stall;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    forward_unit #(.XLEN(32), .NREAD(2), .HIST(1), .RADDR(5)) dut (
        .clk(clk), .reset_n(reset_n), .rs_id(rs_id), .rs_used_id(rs_used_id), .op_id(op_id),
        .rd_ex(rd_ex), .reg_we_ex(reg_we_ex), .ex_is_load(ex_is_load), .alu_result(alu_result),
        .rd_ma(rd_ma), .reg_we_ma(reg_we_ma), .reg_wdata(reg_wdata),
        .op_out(op_out), .fwd_sel(fwd_sel), .load_use_stall(lus), .stall_count(cnt)
    );

    forward_unit #(.XLEN(32), .NREAD(2), .HIST(2), .RADDR(5)) dut2 (
        .clk(clk), .reset_n(reset_n), .rs_id(rs_id), .rs_used_id(rs_used_id), .op_id(op_id),
        .rd_ex(rd_ex), .reg_we_ex(reg_we_ex), .ex_is_load(ex_is_load), .alu_result(alu_result),
        .rd_ma(rd_ma), .reg_we_ma(reg_we_ma), .reg_wdata(reg_wdata),
        .op_out(op_out2), .fwd_sel(fwd_sel2), .load_use_stall(lus2), .stall_count(cnt2)
    );

    task automatic idle();
        reg_we_ex  = 1'b0; ex_is_load = 1'b0; rd_ex = 5'd0; alu_result = 32'd0;
        reg_we_ma  = 1'b0; rd_ma = 5'd0; reg_wdata = 32'd0;
        rs_used_id = 2'b00; rs_id = 10'd0; op_id = 64'd0;
    endtask

    task automatic push_exp(input string n, input bit i2, input logic [63:0] op,
                            input logic [3:0] sel, input logic st);
        exp_t e;
        e.name = n; e.inst2 = i2; e.op = op; e.sel = sel; e.stall = st;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [68:0] act;
        @(negedge clk);
        n_checks++;
        if (cnt !== 32'd0 || cnt2 !== 32'd0) begin
            n_fail++; $display("FAIL reset_count: got %h/%h, expected 0", cnt, cnt2);
        end
        rs_id = {5'd3, 5'd3}; op_id = {32'h33, 32'h31};
        reg_we_ma = 1'b1; rd_ma = 5'd3; reg_wdata = 32'h1234;
        push_exp("rst_ma_live", 1'b0, {32'h1234, 32'h1234}, 4'b1010, 1'b0);
        push_exp("rst_ma_live2", 1'b1, {32'h1234, 32'h1234}, 4'b1010, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.inst2 ? {op_out2, fwd_sel2, lus2} : {op_out, fwd_sel, lus};
            n_checks++;
            if (act !== {e.op, e.sel, e.stall}) begin
                n_fail++;
                $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                         e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
            end
        end
        @(negedge clk);
        reg_we_ma = 1'b0;
        push_exp("rst_no_hist", 1'b0, {32'h33, 32'h31}, 4'b0000, 1'b0);
        push_exp("rst_no_hist2", 1'b1, {32'h33, 32'h31}, 4'b0000, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.inst2 ? {op_out2, fwd_sel2, lus2} : {op_out, fwd_sel, lus};
            n_checks++;
            if (act !== {e.op, e.sel, e.stall}) begin
                n_fail++;
                $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                         e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
            end
        end
        idle();
        reset_n = 1'b1;
    endtask

    task automatic test_ex_ma();
        exp_t e;
        logic [68:0] act;
        @(negedge clk);
        idle();
        rs_id = {5'd2, 5'd1}; op_id = {32'h0BAD_0002, 32'h0BAD_0001};
        reg_we_ex = 1'b1; rd_ex = 5'd1; alu_result = 32'hAAAA_0001;
        reg_we_ma = 1'b1; rd_ma = 5'd2; reg_wdata = 32'h5555_0002;
        push_exp("ex_ma", 1'b0, {32'h5555_0002, 32'hAAAA_0001}, 4'b1001, 1'b0);
        push_exp("ex_ma2", 1'b1, {32'h5555_0002, 32'hAAAA_0001}, 4'b1001, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.inst2 ? {op_out2, fwd_sel2, lus2} : {op_out, fwd_sel, lus};
            n_checks++;
            if (act !== {e.op, e.sel, e.stall}) begin
                n_fail++;
                $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                         e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
            end
        end
    endtask

    task automatic test_history();
        exp_t e;
        logic [68:0] act;
        @(negedge clk);
        idle();
        reg_we_ma = 1'b1; rd_ma = 5'd3; reg_wdata = 32'h1234;
        @(negedge clk);
        idle();
        rs_id = {5'd3, 5'd3};
        push_exp("hist_d1", 1'b0, {32'h1234, 32'h1234}, 4'b1111, 1'b0);
        push_exp("hist_d1_h2", 1'b1, {32'h1234, 32'h1234}, 4'b1111, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.inst2 ? {op_out2, fwd_sel2, lus2} : {op_out, fwd_sel, lus};
            n_checks++;
            if (act !== {e.op, e.sel, e.stall}) begin
                n_fail++;
                $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                         e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
            end
        end
        @(negedge clk);
        op_id = {32'h77, 32'h76};
        push_exp("hist_d2_expired", 1'b0, {32'h77, 32'h76}, 4'b0000, 1'b0);
        push_exp("hist_d2_h2", 1'b1, {32'h1234, 32'h1234}, 4'b1111, 1'b0);
        @(negedge clk);
        #1;
        // Both pushes above are for the previous cycle; re-check the depth-2 expiry here.
        sb.delete();
        push_exp("hist_d3_h2_expired", 1'b1, {32'h77, 32'h76}, 4'b0000, 1'b0);
        push_exp("hist_d3_expired", 1'b0, {32'h77, 32'h76}, 4'b0000, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.inst2 ? {op_out2, fwd_sel2, lus2} : {op_out, fwd_sel, lus};
            n_checks++;
            if (act !== {e.op, e.sel, e.stall}) begin
                n_fail++;
                $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                         e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
            end
        end
        // Newest history entry wins, and MA beats history.
        @(negedge clk);
        idle(); reg_we_ma = 1'b1; rd_ma = 5'd4; reg_wdata = 32'hA;
        @(negedge clk);
        reg_wdata = 32'hB;
        @(negedge clk);
        idle(); rs_id = {5'd4, 5'd4}; op_id = {32'h41, 32'h40};
        push_exp("hist_newest", 1'b0, {32'hB, 32'hB}, 4'b1111, 1'b0);
        push_exp("hist_newest_h2", 1'b1, {32'hB, 32'hB}, 4'b1111, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.inst2 ? {op_out2, fwd_sel2, lus2} : {op_out, fwd_sel, lus};
            n_checks++;
            if (act !== {e.op, e.sel, e.stall}) begin
                n_fail++;
                $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                         e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
            end
        end
        reg_we_ma = 1'b1; rd_ma = 5'd4; reg_wdata = 32'hC;
        push_exp("ma_over_hist", 1'b0, {32'hC, 32'hC}, 4'b1010, 1'b0);
        push_exp("ma_over_hist2", 1'b1, {32'hC, 32'hC}, 4'b1010, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.inst2 ? {op_out2, fwd_sel2, lus2} : {op_out, fwd_sel, lus};
            n_checks++;
            if (act !== {e.op, e.sel, e.stall}) begin
                n_fail++;
                $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                         e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        logic [68:0] act;
        @(negedge clk);
        idle();
        rs_id = {5'd0, 5'd5}; op_id = {32'h99, 32'h88};
        reg_we_ex = 1'b1; rd_ex = 5'd5; alu_result = 32'h11;
        reg_we_ma = 1'b1; rd_ma = 5'd5; reg_wdata = 32'h22;
        push_exp("ex_over_ma", 1'b0, {32'h99, 32'h11}, 4'b0001, 1'b0);
        #1;
        rd_ex = 5'd0; alu_result = 32'hFF; reg_we_ma = 1'b0; rs_id = {5'd0, 5'd0};
        #1;
        // Expectation queued for the earlier pattern is only valid before the change.
        e = sb.pop_front();
        rd_ex = 5'd5; alu_result = 32'h11; reg_we_ma = 1'b1; rs_id = {5'd0, 5'd5};
        #1;
        act = {op_out, fwd_sel, lus};
        n_checks++;
        if (act !== {e.op, e.sel, e.stall}) begin
            n_fail++;
            $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                     e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
        end
        rd_ex = 5'd0; alu_result = 32'hFF; reg_we_ma = 1'b0; rs_id = {5'd0, 5'd0};
        push_exp("x0_never_fwd", 1'b0, {32'h99, 32'h88}, 4'b0000, 1'b0);
        push_exp("x0_never_fwd2", 1'b1, {32'h99, 32'h88}, 4'b0000, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.inst2 ? {op_out2, fwd_sel2, lus2} : {op_out, fwd_sel, lus};
            n_checks++;
            if (act !== {e.op, e.sel, e.stall}) begin
                n_fail++;
                $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                         e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
            end
        end
        reg_we_ex = 1'b0; rd_ex = 5'd5; alu_result = 32'h11;
        reg_we_ma = 1'b1; rd_ma = 5'd5; reg_wdata = 32'h22; rs_id = {5'd5, 5'd5};
        push_exp("same_reg_ports", 1'b0, {32'h22, 32'h22}, 4'b1010, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.inst2 ? {op_out2, fwd_sel2, lus2} : {op_out, fwd_sel, lus};
            n_checks++;
            if (act !== {e.op, e.sel, e.stall}) begin
                n_fail++;
                $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                         e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
            end
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [68:0] act;
        @(negedge clk);
        idle();
        rs_id = {5'd7, 5'd1}; op_id = {32'h70, 32'h10}; rs_used_id = 2'b10;
        ex_is_load = 1'b1; reg_we_ex = 1'b1; rd_ex = 5'd7; alu_result = 32'hDEAD;
        push_exp("load_use", 1'b0, {32'hDEAD, 32'h10}, 4'b0100, 1'b1);
        push_exp("load_use2", 1'b1, {32'hDEAD, 32'h10}, 4'b0100, 1'b1);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.inst2 ? {op_out2, fwd_sel2, lus2} : {op_out, fwd_sel, lus};
            n_checks++;
            if (act !== {e.op, e.sel, e.stall}) begin
                n_fail++;
                $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                         e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
            end
        end
        @(negedge clk);
        n_checks++;
        if (cnt !== 32'd1 || cnt2 !== 32'd1) begin
            n_fail++; $display("FAIL stall_count_inc: got %h/%h, expected 1", cnt, cnt2);
        end
        ex_is_load = 1'b0; reg_we_ex = 1'b0;
        reg_we_ma = 1'b1; rd_ma = 5'd7; reg_wdata = 32'hBEEF;
        push_exp("load_in_ma", 1'b0, {32'hBEEF, 32'h10}, 4'b1000, 1'b0);
        #1;
        ex_is_load = 1'b1; reg_we_ex = 1'b1; reg_we_ma = 1'b0; rs_used_id = 2'b01;
        push_exp("load_unused", 1'b0, {32'hDEAD, 32'h10}, 4'b0100, 1'b0);
        e = sb.pop_front();
        reg_we_ma = 1'b1; ex_is_load = 1'b0; reg_we_ex = 1'b0; rs_used_id = 2'b10;
        #1;
        act = {op_out, fwd_sel, lus};
        n_checks++;
        if (act !== {e.op, e.sel, e.stall}) begin
            n_fail++;
            $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                     e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
        end
        reg_we_ma = 1'b0; ex_is_load = 1'b1; reg_we_ex = 1'b1; rs_used_id = 2'b01;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.inst2 ? {op_out2, fwd_sel2, lus2} : {op_out, fwd_sel, lus};
            n_checks++;
            if (act !== {e.op, e.sel, e.stall}) begin
                n_fail++;
                $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                         e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
            end
        end
        @(negedge clk);
        n_checks++;
        if (cnt !== 32'd1 || cnt2 !== 32'd1) begin
            n_fail++; $display("FAIL stall_count_hold: got %h/%h, expected 1", cnt, cnt2);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] exp2;
        idle();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        rs_id = {5'd7, 5'd1}; rs_used_id = 2'b10;
        ex_is_load = 1'b1; reg_we_ex = 1'b1; rd_ex = 5'd7; alu_result = 32'hDEAD;
        exp2 = 32'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp2 = exp2 + 32'd1;
            n_checks++;
            if (cnt !== 32'hFFFF_FFFF || cnt2 !== exp2) begin
                n_fail++;
                $display("FAIL stall_saturate[%0d]: got %h/%h, expected ffffffff/%h", k, cnt, cnt2, exp2);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [68:0] act;
        idle();
        reg_we_ma = 1'b1; rd_ma = 5'd9; reg_wdata = 32'h99;
        @(negedge clk);
        rd_ma = 5'd10; reg_wdata = 32'h1010;
        @(negedge clk);
        idle(); rs_id = {5'd10, 5'd9}; op_id = {32'hA0, 32'h90};
        push_exp("hist_full", 1'b0, {32'h1010, 32'h90}, 4'b1100, 1'b0);
        push_exp("hist_full2", 1'b1, {32'h1010, 32'h99}, 4'b1111, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.inst2 ? {op_out2, fwd_sel2, lus2} : {op_out, fwd_sel, lus};
            n_checks++;
            if (act !== {e.op, e.sel, e.stall}) begin
                n_fail++;
                $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                         e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
            end
        end
        reset_n = 1'b0;
        push_exp("mid_rst_flush", 1'b0, {32'hA0, 32'h90}, 4'b0000, 1'b0);
        push_exp("mid_rst_flush2", 1'b1, {32'hA0, 32'h90}, 4'b0000, 1'b0);
        #1;
        n_checks++;
        if (cnt !== 32'd0 || cnt2 !== 32'd0) begin
            n_fail++; $display("FAIL mid_rst_count: got %h/%h, expected 0", cnt, cnt2);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.inst2 ? {op_out2, fwd_sel2, lus2} : {op_out, fwd_sel, lus};
            n_checks++;
            if (act !== {e.op, e.sel, e.stall}) begin
                n_fail++;
                $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                         e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
            end
        end
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        push_exp("post_rst", 1'b0, {32'hA0, 32'h90}, 4'b0000, 1'b0);
        push_exp("post_rst2", 1'b1, {32'hA0, 32'h90}, 4'b0000, 1'b0);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = e.inst2 ? {op_out2, fwd_sel2, lus2} : {op_out, fwd_sel, lus};
            n_checks++;
            if (act !== {e.op, e.sel, e.stall}) begin
                n_fail++;
                $display("FAIL %s: got op=%h sel=%b stall=%b, expected op=%h sel=%b stall=%b",
                         e.name, act[68:5], act[4:1], act[0], e.op, e.sel, e.stall);
            end
        end
        n_checks++;
        if (cnt !== 32'd0 || cnt2 !== 32'd0) begin
            n_fail++; $display("FAIL post_rst_count: got %h/%h, expected 0", cnt, cnt2);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        test_reset();
        test_ex_ma();
        test_history();
        test_priority();
        test_load_use();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/forward_unit.md
# forward_unit

Parametrised operand-forwarding and load-use hazard unit for the pipelined core, placed between ID operand fetch and the EX ALU inputs. It resolves NREAD source operands against the EX result, the MA write-back value and a HIST-deep history of retired write-backs, with age priority. It also flags load-use hazards that forwarding cannot cover, and counts the stall cycles this costs.

## Interface
- XLEN, 32, datapath width
- NREAD, 2, number of source operands forwarded (1..4)
- HIST, 1, retired write-back history depth after MA (1..4); covers register-file write-before-read gap
- RADDR, 5, register address width
- clk  in  1  core clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rs_id  in  NREAD*RADDR  source register index per operand; operand i at [i*RADDR +: RADDR]
- rs_used_id  in  NREAD  operand i actually read by the ID instruction
- op_id  in  NREAD*XLEN  register-file value per operand
- rd_ex, reg_we_ex, ex_is_load  in  RADDR/1/1  EX destination, write enable, EX result is a load (value not yet available)
- alu_result  in  XLEN  EX result
- rd_ma, reg_we_ma  in  RADDR/1  MA destination and write enable
- reg_wdata  in  XLEN  MA write-back value
- op_out  out  NREAD*XLEN  forwarded operand per port
- fwd_sel  out  NREAD*2  per-port source: 0 regfile, 1 EX, 2 MA, 3 history
- load_use_stall  out  1  ID must hold one cycle
- stall_count  out  32  saturating count of load_use_stall cycles

## Operation
- Per port i, sources in strict priority; first match wins:
  1. EX: reg_we_ex, rd_ex!=0, rd_ex==rs_i. Selects alu_result.
  2. MA: reg_we_ma, rd_ma!=0, rd_ma==rs_i. Selects reg_wdata.
  3. History: entry h=0 (newest) to HIST-1 (oldest), with entry we, rd!=0, rd==rs_i. Selects that entry's data. The lowest h wins.
  4. Otherwise op_id.
- rs_i==0 always yields op_id (x0 never forwarded).
- History is a shift register of {we, rd, data}. Every clk edge, entry 0 <= {reg_we_ma, rd_ma, reg_wdata} and entry h <= entry h-1. It shifts unconditionally, including during load_use_stall, because MA keeps retiring.
- load_use_stall = OR over i of (rs_used_id[i] & ex_is_load & reg_we_ex & rd_ex!=0 & rd_ex==rs_i).
  - During a stall, op_out for the hit port still shows alu_result (don't-care to consumer).
  - Next cycle the load is in MA and forwards via priority 2.
- stall_count increments by 1 on each edge where load_use_stall=1. It saturates at 0xFFFF_FFFF and does not wrap.

## Timing
- op_out, fwd_sel and load_use_stall are purely combinational from inputs and history. They have zero-cycle latency and no register on the output.
- History and stall_count update on rising clk.
- Reset (reset_n low, asynchronous):
  - All history we bits clear to 0; rd and data clear to 0.
  - stall_count clears to 0.
  - While reset_n is low, outputs still follow EX/MA/op_id combinationally; history never matches.
- Reset asserted mid-operation drops all pending history instantly. The first cycle after release forwards only from EX/MA.
- When EX and MA both write the same rd, EX wins. When history entries share an rd, the newest wins.
- Two ports naming the same register receive identical values and identical fwd_sel.

## Test plan
- rs_id={1,2}, EX writes x1=0xAAAA_0001, MA writes x2=0x5555_0002 -> op_out={0xAAAA_0001,0x5555_0002}, fwd_sel={1,2}.
- Write x3=0x1234 via MA, then one idle cycle, then read x3 with op_id=0 (HIST=1) -> op_out=0x1234, fwd_sel=3. With HIST=2 the value is still forwarded one cycle later; after HIST+1 idle cycles op_out=op_id.
- EX and MA both write x5 (0x11, 0x22), rs=x5 -> 0x11. With rs=x0 and EX writing x0=0xFF -> op_out=op_id, fwd_sel=0.
- ex_is_load, rd_ex=x7, rs_used_id[1]=1, rs1=x7 -> load_use_stall=1, stall_count 0->1. Same case with rs_used_id[1]=0 -> no stall.
- Preload stall_count=0xFFFF_FFFE, then 3 stall cycles -> ends at 0xFFFF_FFFF.
- Fill history, pulse reset_n low mid-cycle -> stall_count=0 immediately and no history match afterwards.
